// File: rtl/mac_accum_if.sv
// Bus between the frame sequencing controller/consumer and the mac_accum datapath.
interface mac_accum_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACCW  = 20
);
    logic [1:0]         muxControl;
    logic               enData;
    logic               clearAccum;
    logic [4*WIDTH-1:0] in_words;
    logic [4*WIDTH-1:0] coefs;
    logic               out_ready;
    logic               clr_flags;
    logic               out_valid;
    logic [ACCW-1:0]    out_data;
    logic               overflow;
    logic               saturated;

    modport master (
        output muxControl, enData, clearAccum, in_words, coefs, out_ready, clr_flags,
        input  out_valid, out_data, overflow, saturated
    );

    modport slave (
        input  muxControl, enData, clearAccum, in_words, coefs, out_ready, clr_flags,
        output out_valid, out_data, overflow, saturated
    );
endinterface

// File: rtl/mac_accum.sv
// Signed four-tap saturating multiply-accumulate with a 2-entry result FIFO.
// One tap per cycle; the end-of-frame sum is pushed and drained via valid/ready.
module mac_accum #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACCW  = 20
) (
    input  logic         ph1,
    input  logic         reset,
    mac_accum_if.slave   bus
);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned SW   = ACCW + 1;
    localparam int unsigned CNTW = 2;

    localparam logic signed [SW-1:0] MAXV = {2'b00, {(ACCW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {2'b11, {(ACCW-1){1'b0}}};

    logic signed [WIDTH-1:0] samp_q   [4];
    logic signed [WIDTH-1:0] live_w_c [4];
    logic signed [WIDTH-1:0] coef_w_c [4];
    logic signed [ACCW-1:0]  acc;
    logic signed [WIDTH-1:0] word_c;
    logic signed [WIDTH-1:0] coef_c;
    logic signed [PW-1:0]    prod_c;
    logic signed [SW-1:0]    sum_c;
    logic signed [ACCW-1:0]  clamp_c;
    logic                    clamp_hit_c;

    logic [CNTW-1:0]         count;
    logic [CNTW-1:0]         cnt_n;
    logic signed [ACCW-1:0]  head;
    logic signed [ACCW-1:0]  head_n;
    logic signed [ACCW-1:0]  tail;
    logic signed [ACCW-1:0]  tail_n;
    logic                    valid_q;
    logic                    pop_c;
    logic                    drop_c;
    logic                    overflow_q;
    logic                    saturated_q;

    // Tap datapath: tap 00 reads live samples, later taps read the captured copy.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            live_w_c[k] = bus.in_words[k*WIDTH +: WIDTH];
            coef_w_c[k] = bus.coefs[k*WIDTH +: WIDTH];
        end
        word_c = (bus.muxControl == 2'd0) ? live_w_c[0] : samp_q[bus.muxControl];
        coef_c = coef_w_c[bus.muxControl];
        prod_c = PW'(word_c) * PW'(coef_c);
        sum_c  = SW'(acc) + SW'(prod_c);
        clamp_hit_c = 1'b0;
        clamp_c     = ACCW'(sum_c);
        if (sum_c > MAXV) begin
            clamp_c     = ACCW'(MAXV);
            clamp_hit_c = 1'b1;
        end else if (sum_c < MINV) begin
            clamp_c     = ACCW'(MINV);
            clamp_hit_c = 1'b1;
        end
    end

    // FIFO next state; a push into a full FIFO survives only alongside a pop.
    always_comb begin
        pop_c  = (count != '0) && bus.out_ready;
        cnt_n  = count;
        head_n = head;
        tail_n = tail;
        drop_c = bus.enData && (count == CNTW'(2)) && !pop_c;
        case (count)
            2'd0: begin
                if (bus.enData) begin
                    head_n = clamp_c;
                    cnt_n  = CNTW'(1);
                end
            end
            2'd1: begin
                if (pop_c && bus.enData) begin
                    head_n = clamp_c;
                end else if (pop_c) begin
                    cnt_n = CNTW'(0);
                end else if (bus.enData) begin
                    tail_n = clamp_c;
                    cnt_n  = CNTW'(2);
                end
            end
            2'd2: begin
                if (pop_c) begin
                    head_n = tail;
                    if (bus.enData) begin
                        tail_n = clamp_c;
                    end else begin
                        cnt_n = CNTW'(1);
                    end
                end
            end
            default: cnt_n = CNTW'(0);
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            for (int k = 0; k < 4; k++) samp_q[k] <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            acc <= bus.clearAccum ? '0 : clamp_c;
            if (bus.muxControl == 2'd0) begin
                for (int k = 0; k < 4; k++) samp_q[k] <= live_w_c[k];
            end
            count   <= cnt_n;
            head    <= head_n;
            tail    <= tail_n;
            valid_q <= (cnt_n != '0);
            // Set beats a same-cycle clear.
            overflow_q  <= drop_c      | (overflow_q  & ~bus.clr_flags);
            saturated_q <= clamp_hit_c | (saturated_q & ~bus.clr_flags);
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = head;
    assign bus.overflow  = overflow_q;
    assign bus.saturated = saturated_q;
endmodule

// File: tb/tb_mac_accum.sv
// Directed self-checking bench for mac_accum (ACCW=20 main instance, ACCW=16 saturation instance).
module tb_mac_accum;
    localparam int unsigned W = 8;

    logic ph1;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mac_accum_if #(.WIDTH(W), .ACCW(20)) bus_a ();
    mac_accum_if #(.WIDTH(W), .ACCW(16)) bus_b ();

    mac_accum #(.WIDTH(W), .ACCW(20)) dut_a (.ph1(ph1), .reset(reset), .bus(bus_a));
    mac_accum #(.WIDTH(W), .ACCW(16)) dut_b (.ph1(ph1), .reset(reset), .bus(bus_b));

    assign bus_b.muxControl = bus_a.muxControl;
    assign bus_b.enData     = bus_a.enData;
    assign bus_b.clearAccum = bus_a.clearAccum;
    assign bus_b.in_words   = bus_a.in_words;
    assign bus_b.coefs      = bus_a.coefs;
    assign bus_b.out_ready  = bus_a.out_ready;
    assign bus_b.clr_flags  = bus_a.clr_flags;

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    typedef struct {
        logic [4*W-1:0] words;
        logic [4*W-1:0] coefs;
        longint         exp;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [4*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_tap(input logic [1:0] t, input logic [4*W-1:0] words,
                             input logic [4*W-1:0] coefs, input logic en, input logic clr,
                             input logic ready, input logic cflags);
        @(negedge ph1);
        bus_a.muxControl = t;
        bus_a.in_words   = words;
        bus_a.coefs      = coefs;
        bus_a.enData     = en;
        bus_a.clearAccum = clr;
        bus_a.out_ready  = ready;
        bus_a.clr_flags  = cflags;
        @(posedge ph1);
        #1;
    endtask

    task automatic idle(input logic ready, input logic cflags);
        drive_tap(2'd0, '0, '0, 1'b0, 1'b1, ready, cflags);
    endtask

    // Tap 00 sees 'words'; taps 01..11 see 'alt' on in_words.
    task automatic run_frame(input logic [4*W-1:0] words, input logic [4*W-1:0] alt,
                             input logic [4*W-1:0] coefs, input logic ready_early,
                             input logic ready_last);
        drive_tap(2'd0, words, coefs, 1'b0, 1'b0, ready_early, 1'b0);
        drive_tap(2'd1, alt,   coefs, 1'b0, 1'b0, ready_early, 1'b0);
        drive_tap(2'd2, alt,   coefs, 1'b0, 1'b0, ready_early, 1'b0);
        drive_tap(2'd3, alt,   coefs, 1'b1, 1'b1, ready_last,  1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [4*W-1:0] w10, w20, w30, ones, w1234, c5678;
        w10   = pack4(1, 2, 3, 4);
        w20   = pack4(2, 4, 6, 8);
        w30   = pack4(3, 6, 9, 12);
        ones  = pack4(1, 1, 1, 1);
        w1234 = pack4(1, 2, 3, 4);
        c5678 = pack4(5, 6, 7, 8);

        vecs[0] = '{words: w1234,                         coefs: c5678,                        exp: 70};
        vecs[1] = '{words: pack4(-1, -1, -1, -1),         coefs: ones,                         exp: -4};
        vecs[2] = '{words: pack4(-128, -128, -128, -128), coefs: pack4(-128, -128, -128, -128), exp: 65536};
        vecs[3] = '{words: pack4(127, -128, 0, 5),        coefs: pack4(-128, 127, 3, -2),      exp: -32522};
        vecs[4] = '{words: pack4(10, 20, 30, 40),         coefs: pack4(-1, 2, -3, 4),          exp: 100};

        reset = 1'b1;
        bus_a.muxControl = 2'd0;
        bus_a.in_words   = '0;
        bus_a.coefs      = '0;
        bus_a.enData     = 1'b0;
        bus_a.clearAccum = 1'b1;
        bus_a.out_ready  = 1'b1;
        bus_a.clr_flags  = 1'b0;
        repeat (2) @(posedge ph1);
        #1;
        check("reset_valid",     longint'(bus_a.out_valid), 0);
        check("reset_data",      longint'($signed(bus_a.out_data)), 0);
        check("reset_overflow",  longint'(bus_a.overflow), 0);
        check("reset_saturated", longint'(bus_a.saturated), 0);
        @(negedge ph1);
        reset = 1'b0;

        // Table-driven frames, consumer always ready.
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].words, vecs[i].words, vecs[i].coefs, 1'b1, 1'b1);
            check($sformatf("vec%0d_valid", i), longint'(bus_a.out_valid), 1);
            check($sformatf("vec%0d_data", i),  longint'($signed(bus_a.out_data)), vecs[i].exp);
        end
        check("vec_no_sat_a", longint'(bus_a.saturated), 0);

        // Later taps must use samples captured at tap 00.
        run_frame(w10, pack4(9, 9, 9, 9), ones, 1'b1, 1'b1);
        check("capture_data", longint'($signed(bus_a.out_data)), 10);

        // Saturation on the narrow instance.
        idle(1'b1, 1'b1);
        check("sat_pre_clear_b", longint'(bus_b.saturated), 0);
        run_frame(pack4(127, 127, 127, 127), pack4(127, 127, 127, 127), pack4(127, 127, 127, 127), 1'b1, 1'b1);
        check("sat_pos_data_b", longint'($signed(bus_b.out_data)), 32767);
        check("sat_pos_flag_b", longint'(bus_b.saturated), 1);
        check("sat_pos_data_a", longint'($signed(bus_a.out_data)), 64516);
        check("sat_pos_flag_a", longint'(bus_a.saturated), 0);
        run_frame(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 1'b1, 1'b1);
        check("sat_neg_data_b", longint'($signed(bus_b.out_data)), -32768);
        check("sat_neg_data_a", longint'($signed(bus_a.out_data)), -65024);
        idle(1'b1, 1'b1);
        check("sat_cleared_b", longint'(bus_b.saturated), 0);

        // Overflow: three results with the consumer stalled.
        idle(1'b1, 1'b1);
        run_frame(w10, w10, ones, 1'b0, 1'b0);
        run_frame(w20, w20, ones, 1'b0, 1'b0);
        check("full_no_ovf", longint'(bus_a.overflow), 0);
        run_frame(w30, w30, ones, 1'b0, 1'b0);
        check("ovf_flag", longint'(bus_a.overflow), 1);
        check("ovf_head", longint'($signed(bus_a.out_data)), 10);
        idle(1'b0, 1'b0);
        check("ovf_hold", longint'($signed(bus_a.out_data)), 10);
        idle(1'b1, 1'b0);
        check("ovf_pop2", longint'($signed(bus_a.out_data)), 20);
        check("ovf_pop2_valid", longint'(bus_a.out_valid), 1);
        idle(1'b1, 1'b0);
        check("ovf_empty", longint'(bus_a.out_valid), 0);
        check("ovf_sticky", longint'(bus_a.overflow), 1);

        // Push and pop together while full.
        idle(1'b0, 1'b1);
        check("ovf_cleared", longint'(bus_a.overflow), 0);
        run_frame(w10, w10, ones, 1'b0, 1'b0);
        run_frame(w20, w20, ones, 1'b0, 1'b0);
        run_frame(w30, w30, ones, 1'b0, 1'b1);
        check("pp_head", longint'($signed(bus_a.out_data)), 20);
        check("pp_no_ovf", longint'(bus_a.overflow), 0);
        idle(1'b1, 1'b0);
        check("pp_tail", longint'($signed(bus_a.out_data)), 30);
        check("pp_tail_valid", longint'(bus_a.out_valid), 1);
        idle(1'b1, 1'b0);
        check("pp_empty", longint'(bus_a.out_valid), 0);

        // Reset mid-frame with one entry pending.
        run_frame(w1234, w1234, c5678, 1'b0, 1'b0);
        check("rst_pending", longint'(bus_a.out_valid), 1);
        drive_tap(2'd0, w1234, c5678, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_tap(2'd1, w1234, c5678, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", longint'(bus_a.out_valid), 0);
        check("rst_mid_data",  longint'($signed(bus_a.out_data)), 0);
        @(negedge ph1);
        reset = 1'b0;
        run_frame(w1234, w1234, c5678, 1'b1, 1'b1);
        check("rst_after_valid", longint'(bus_a.out_valid), 1);
        check("rst_after_data",  longint'($signed(bus_a.out_data)), 70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_accum.md
# mac_accum

Signed four-tap multiply-accumulate datapath. It sits directly downstream of the four-state sequencing controller and consumes that controller's `muxControl`, `enData` and `clearAccum` outputs. Over each four-cycle frame it multiplies four sample words by four coefficients and sums the products into a saturating accumulator. At the end of each frame it pushes the result into a 2-entry output FIFO, drained through a valid/ready handshake.

## Interface
- `WIDTH`, 8: bit width of each sample and coefficient, signed two's complement.
- `ACCW`, 20: accumulator and result width, signed. Must be ≥ 2*WIDTH.

- `ph1`, in, 1: the block's single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `muxControl`, in, 2: tap select from the controller (00,01,10,11 per frame).
- `enData`, in, 1: end of frame; push result to FIFO this cycle.
- `clearAccum`, in, 1: zero the accumulator after this cycle's update.
- `in_words`, in, 4*WIDTH: samples; word k is bits [k*WIDTH +: WIDTH].
- `coefs`, in, 4*WIDTH: coefficients, same packing.
- `out_ready`, in, 1: consumer accepts `out_data` this cycle.
- `clr_flags`, in, 1: synchronous clear of the sticky flags.
- `out_valid`, out, 1: FIFO non-empty.
- `out_data`, out, ACCW: FIFO head entry.
- `overflow`, out, 1: sticky; a result was dropped because the FIFO was full.
- `saturated`, out, 1: sticky; an accumulation clamped.

## Operation
- Sample capture:
  - When `muxControl`=00, the tap uses word 0 from the live `in_words`.
  - In the same cycle, all four words are registered into `samp_q`.
  - Taps 01/10/11 use `samp_q[k]`.
  - `coefs` is used live and is held stable by the system.
- Product: `p` = signed(word k) * signed(coef k), 2*WIDTH bits, sign-extended to ACCW+1.
- Sum: `s` = sign-extended `acc` + `p`, computed in ACCW+1 bits.
  - Clamp to [−2^(ACCW−1), 2^(ACCW−1)−1].
  - On clamp, `saturated` is set.
- Accumulator update: `acc` ← 0 if `clearAccum`, else the clamped `s`.
- Push:
  - When `enData`=1, the clamped `s` (not the post-clear `acc`) is written to the FIFO tail.
  - With the controller's fixed sequence, `enData` and `clearAccum` coincide at tap 11. Each frame's result is therefore p0+p1+p2+p3, and the next frame starts from 0.
  - `enData` without `clearAccum` still pushes the running sum; `acc` keeps it.
- FIFO: 2 entries with a count register (0..2).
  - Pop occurs when `out_valid` && `out_ready`.
  - Push with count<2: accepted.
  - Push with count=2 and pop in the same cycle: accepted. Count stays 2 and order is preserved.
  - Push with count=2 and no pop: result dropped, `overflow` set. FIFO unchanged.
  - Pop with count=0: ignored.
- Sticky flags: cleared by `clr_flags` or reset.
  - If a set event and `clr_flags` occur in the same cycle, set wins.

## Timing
- Reset values: `acc`=0, `samp_q`=0, FIFO empty, `out_valid`=0, `out_data`=0, `overflow`=0, `saturated`=0.
- Reset asserted mid-frame discards the partial sum and all FIFO contents immediately. After release, accumulation resumes on the next edge from `acc`=0.
- Latency: the result pushed at the tap-11 edge appears on `out_data` with `out_valid`=1 in the following cycle. That is 1 cycle after `enData`, or 4 cycles after the tap-00 cycle.
- `out_data` is the registered FIFO head. It holds stable while `out_valid`=1 and `out_ready`=0.
- Throughput: one result per 4 cycles. A consumer holding `out_ready` low for ≥9 cycles with an empty FIFO causes an overflow on the 3rd push.
- `muxControl` values outside the 00→11 order are still honoured per cycle. Only the 00 value captures `samp_q`.

## Test plan
- Basic frame (WIDTH=8, ACCW=20):
  - Stimulus: words {1,2,3,4}, coefs {5,6,7,8}, one controller frame.
  - Required: `out_data`=70 with `out_valid`=1 one cycle after `enData`.
  - Next frame with words {−1,−1,−1,−1}, coefs {1,1,1,1}: `out_data`=−4, confirming the clear between frames.
- Sample capture:
  - Stimulus: words {1,2,3,4} at tap 00, then `in_words` changed to {9,9,9,9} at taps 01–11, coefs all 1.
  - Required: result 10.
- Saturation (ACCW=16):
  - Words all 127, coefs all 127 → `out_data`=32767, `saturated`=1.
  - Words all −128, coefs all 127 → −32768.
  - `clr_flags` pulse → `saturated`=0.
- FIFO full/overflow:
  - Stimulus: `out_ready`=0 for 3 frames with results 10, 20, 30.
  - Required: `overflow`=1 and the FIFO holds 10, 20.
  - Then `out_ready`=1: pops yield 10 then 20, then `out_valid`=0.
- Simultaneous push/pop when full:
  - Stimulus: FIFO holds {10,20}, `out_ready`=1 in the `enData` cycle of a frame producing 30.
  - Required: 10 pops, FIFO becomes {20,30}, `overflow` stays 0.
- Reset mid-frame:
  - Stimulus: assert `reset` between taps 01 and 10 with one FIFO entry pending.
  - Required: `out_valid`=0 and `out_data`=0 immediately. The next full frame of {1,2,3,4}×{5,6,7,8} yields 70.
